// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: arbitration mode, FSM state and the
// channel-index width helper.
package rv32i_types;

  typedef enum logic {FIXED = 1'b0, RR = 1'b1} arb_mode_t;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // A single channel still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first active request at or after start,
// wrapping past the top channel back to 0.
module arb_pick
  import rv32i_types::*;
#(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  // One extra bit so start+offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, start} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_CH)) cand = cand - (IDX_W+1)'(NUM_CH);
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter in front of one shared cacheline memory port; one
// transfer in flight, request fields latched at grant time.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int        NUM_CH  = 2,
  parameter int        ADDR_W  = 32,
  parameter int        DATA_W  = 256,
  parameter arb_mode_t RR_MODE = RR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic [NUM_CH-1:0]              ch_resp,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_resp,
  output logic                           busy
);

  localparam int IDX_W = idx_w(NUM_CH);

  arb_state_t        state;
  logic [IDX_W-1:0]  grant, last_grant, start, pick_idx;
  logic              pick_valid;
  logic [NUM_CH-1:0] req;

  assign req      = ch_read | ch_write;
  assign ch_rdata = mem_rdata;

  // Fixed priority always searches from channel 0.
  always_comb begin
    start = '0;
    if (RR_MODE == RR)
      start = (last_grant == IDX_W'(NUM_CH-1)) ? '0 : last_grant + 1'b1;
  end

  arb_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .start (start),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_CH-1);
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_valid) begin
          state     <= BUSY;
          busy      <= 1'b1;
          grant     <= pick_idx;
          // Read wins if a channel raises both.
          mem_read  <= ch_read[pick_idx];
          mem_write <= ~ch_read[pick_idx];
          mem_addr  <= ch_addr[pick_idx];
          mem_wdata <= ch_wdata[pick_idx];
          if (RR_MODE == RR) last_grant <= pick_idx;
        end
        BUSY: if (mem_resp) begin
          state     <= IDLE;
          busy      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion pulse goes only to the granted channel, and only while a
  // transfer is actually outstanding.
  always_comb begin
    ch_resp = '0;
    if (state == BUSY && mem_resp) ch_resp[grant] = 1'b1;
  end

  a_rw_excl: assert property (@(posedge clk) disable iff (rst) (ch_read & ch_write) == '0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: 2-channel round-robin and fixed-priority
// instances in lockstep on shared stimulus, plus a 4-channel round-robin one.
module tb_mem_arbiter;
  import rv32i_types::*;

  localparam int AW = 32, DW = 256, CAW = 16, CDW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]          ch_read, ch_write;
  logic [1:0][AW-1:0]  ch_addr;
  logic [1:0][DW-1:0]  ch_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                a_mresp, b_mresp;
  logic [DW-1:0]       a_rdata, b_rdata, a_mwdata, b_mwdata;
  logic [1:0]          a_resp, b_resp;
  logic                a_mread, a_mwrite, a_busy, b_mread, b_mwrite, b_busy;
  logic [AW-1:0]       a_maddr, b_maddr;

  logic [3:0]          c_read, c_write, c_resp;
  logic [3:0][CAW-1:0] c_addr;
  logic [3:0][CDW-1:0] c_wdata;
  logic [CDW-1:0]      c_mrdata, c_rdata, c_mwdata;
  logic [CAW-1:0]      c_maddr;
  logic                c_mresp, c_mread, c_mwrite, c_busy;

  int n_cmp = 0, n_err = 0;
  int a_q[$], b_q[$], c_q[$];
  int a_cnt = 0, b_cnt = 0, c_cnt = 0;
  bit auto_on = 1'b0;
  logic [DW-1:0] exp_rd;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(RR)) u_a (
    .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(a_rdata), .ch_resp(a_resp), .mem_read(a_mread),
    .mem_write(a_mwrite), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(mem_rdata),
    .mem_resp(a_mresp), .busy(a_busy));

  mem_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(FIXED)) u_b (
    .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_rdata(b_rdata), .ch_resp(b_resp), .mem_read(b_mread),
    .mem_write(b_mwrite), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(mem_rdata),
    .mem_resp(b_mresp), .busy(b_busy));

  mem_arbiter #(.NUM_CH(4), .ADDR_W(CAW), .DATA_W(CDW), .RR_MODE(RR)) u_c (
    .clk(clk), .rst(rst), .ch_read(c_read), .ch_write(c_write), .ch_addr(c_addr),
    .ch_wdata(c_wdata), .ch_rdata(c_rdata), .ch_resp(c_resp), .mem_read(c_mread),
    .mem_write(c_mwrite), .mem_addr(c_maddr), .mem_wdata(c_mwdata), .mem_rdata(c_mrdata),
    .mem_resp(c_mresp), .busy(c_busy));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Auto memory model: responds in the third cycle of an outstanding request.
  task automatic resp_step(input logic act, inout int cnt, output logic r);
    r = 1'b0;
    if (act) begin
      cnt++;
      if (cnt == 3) begin r = 1'b1; cnt = 0; end
    end else cnt = 0;
  endtask

  task automatic wait_resp(input int which, input string tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((which == 0 && a_resp != 2'b00) || (which == 2 && c_resp != 4'b0000)) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $error("FAIL %s: no ch_resp within 60 cycles", tag);
  endtask

  initial begin
    rst = 1'b1; ch_read = '0; ch_write = '0; ch_addr = '0; ch_wdata = '0; mem_rdata = '0;
    a_mresp = 1'b0; b_mresp = 1'b0;
    c_read = '0; c_write = '0; c_wdata = '0; c_mrdata = '0; c_mresp = 1'b0;
    for (int i = 0; i < 4; i++) c_addr[i] = CAW'(16'h0100 * i + 16'h0010);

    fork
      forever begin
        @(posedge clk); #1;
        if (auto_on) begin
          resp_step(a_mread | a_mwrite, a_cnt, a_mresp);
          resp_step(b_mread | b_mwrite, b_cnt, b_mresp);
          resp_step(c_mread | c_mwrite, c_cnt, c_mresp);
        end
      end
      // Scoreboard: every completion pulse must match the next expected grant.
      forever begin
        @(negedge clk);
        if (a_resp !== 2'b00) begin
          if (a_q.size() == 0) chk("a_unexpected_resp", a_resp, 0);
          else chk("a_grant", a_resp, 256'(1) << a_q.pop_front());
        end
        if (b_resp !== 2'b00) begin
          if (b_q.size() == 0) chk("b_unexpected_resp", b_resp, 0);
          else chk("b_grant", b_resp, 256'(1) << b_q.pop_front());
        end
        if (c_resp !== 4'b0000) begin
          if (c_q.size() == 0) chk("c_unexpected_resp", c_resp, 0);
          else chk("c_grant", c_resp, 256'(1) << c_q.pop_front());
        end
      end
      begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("a_rst_ctl", {a_busy, a_mread, a_mwrite, a_resp}, 0);
    chk("a_rst_addr", a_maddr, 0);
    chk("a_rst_wdata", a_mwdata, 0);
    chk("b_rst_ctl", {b_busy, b_mread, b_mwrite, b_resp}, 0);
    chk("c_rst_ctl", {c_busy, c_mread, c_mwrite, c_resp}, 0);
    chk("c_rst_addr", {c_maddr, c_mwdata}, 0);

    // Single read on ch1, memory answers 5 cycles after mem_read rises
    tick();
    ch_read = 2'b10; ch_addr[1] = 32'h0000_1000;
    a_q.push_back(1); b_q.push_back(1);
    tick();
    @(negedge clk);
    chk("a_t1_ctl", {a_busy, a_mread, a_mwrite}, 3'b110);
    chk("a_t1_addr", a_maddr, 32'h0000_1000);
    chk("b_t1_ctl", {b_busy, b_mread, b_mwrite}, 3'b110);
    repeat (4) tick();
    @(negedge clk);
    chk("a_t5_hold", {a_busy, a_mread, a_maddr}, {2'b11, 32'h0000_1000});
    tick();
    exp_rd = {8{$urandom()}};
    mem_rdata = exp_rd; a_mresp = 1'b1; b_mresp = 1'b1;
    @(negedge clk);
    chk("a_t6_resp", a_resp, 2'b10);
    chk("a_t6_rdata", a_rdata, exp_rd);
    chk("b_t6_rdata", b_rdata, exp_rd);
    tick();
    a_mresp = 1'b0; b_mresp = 1'b0; ch_read = 2'b00;
    @(negedge clk);
    chk("a_t7_idle", {a_busy, a_mread, a_mwrite, a_resp}, 0);
    chk("b_t7_idle", {b_busy, b_mread, b_mwrite, b_resp}, 0);

    // Stray mem_resp while idle
    tick();
    a_mresp = 1'b1; b_mresp = 1'b1;
    @(negedge clk);
    chk("stray_resp", {a_resp, b_resp, a_busy, b_busy}, 0);
    tick();
    a_mresp = 1'b0; b_mresp = 1'b0;

    // Both channels requesting continuously for four transfers
    auto_on = 1'b1;
    tick();
    ch_read = 2'b11; ch_addr[0] = 32'h0000_2000;
    a_q.push_back(0); a_q.push_back(1); a_q.push_back(0); a_q.push_back(1);
    repeat (4) b_q.push_back(0);
    for (int n = 0; n < 4; n++) begin
      wait_resp(0, "ab_stream_timeout");
      tick();
      if (n == 3) ch_read = 2'b00;
      @(negedge clk);
      chk("ab_bubble", {a_busy, b_busy}, 2'b00);
      if (n < 3) begin
        tick();
        @(negedge clk);
        chk("ab_regrant", {a_busy, b_busy}, 2'b11);
        tick();
      end
    end
    tick();
    @(negedge clk);
    chk("ab_no_regrant", {a_busy, b_busy}, 2'b00);
    auto_on = 1'b0;

    // Write on ch0; address and data change mid-transfer
    tick();
    ch_write = 2'b01; ch_addr[0] = 32'h0000_4440; ch_wdata[0] = {32{8'hA5}};
    a_q.push_back(0); b_q.push_back(0);
    tick();
    @(negedge clk);
    chk("a_wr_ctl", {a_mwrite, a_mread}, 2'b10);
    chk("a_wr_addr", a_maddr, 32'h0000_4440);
    chk("a_wr_data", a_mwdata, {32{8'hA5}});
    tick();
    ch_addr[0] = 32'hFFFF_0000; ch_wdata[0] = {32{8'h5A}};
    tick();
    @(negedge clk);
    chk("a_wr_addr_held", a_maddr, 32'h0000_4440);
    chk("a_wr_data_held", a_mwdata, {32{8'hA5}});
    chk("b_wr_held", {b_maddr, b_mwdata}, {32'h0000_4440, {32{8'hA5}}});
    tick();
    a_mresp = 1'b1; b_mresp = 1'b1;
    tick();
    a_mresp = 1'b0; b_mresp = 1'b0; ch_write = 2'b00;
    @(negedge clk);
    chk("ab_wr_done", {a_busy, b_busy, a_mwrite, b_mwrite}, 0);

    // Reset two cycles into a read, then a late memory response
    tick();
    ch_read = 2'b01; ch_addr[0] = 32'h0000_8000;
    tick();
    @(negedge clk);
    chk("a_abort_busy", {a_busy, a_mread}, 2'b11);
    tick();
    rst = 1'b1; ch_read = 2'b00;
    tick();
    rst = 1'b0; a_mresp = 1'b1; b_mresp = 1'b1;
    @(negedge clk);
    chk("a_abort_ctl", {a_busy, a_mread, a_mwrite, a_resp}, 0);
    chk("a_abort_fields", {a_maddr, a_mwdata}, 0);
    chk("b_abort_ctl", {b_busy, b_mread, b_mwrite, b_resp}, 0);
    tick();
    a_mresp = 1'b0; b_mresp = 1'b0;
    @(negedge clk);
    chk("ab_abort_idle", {a_busy, b_busy}, 2'b00);

    // Four channels: ch3 first, then wrap to ch0, then rotate 2,3,0
    auto_on = 1'b1;
    tick();
    c_read = 4'b1000; c_q.push_back(3);
    wait_resp(2, "c_timeout");
    tick();
    c_read = 4'b1001; c_q.push_back(0);
    wait_resp(2, "c_timeout");
    tick();
    c_read = 4'b1101; c_q.push_back(2); c_q.push_back(3); c_q.push_back(0);
    tick();
    @(negedge clk);
    chk("c_after_wrap_addr", c_maddr, 16'h0210);
    for (int n = 0; n < 3; n++) begin
      wait_resp(2, "c_timeout");
      tick();
    end
    c_read = 4'b0000;
    tick();
    @(negedge clk);
    chk("c_idle_end", {c_busy, c_mread}, 2'b00);
    auto_on = 1'b0;

    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    chk("c_queue_drained", c_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
